// File: rtl/ctrl_uplink_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_uplink_arbiter_pkg
// Shared parameters and types for the control uplink arbiter: default message
// width, where the header field sits inside a message, the header code of a
// result message, and the arbiter FSM state type.
// ---------------------------------------------------------------------------
package ctrl_uplink_arbiter_pkg;

    localparam int CTRL_FIFO_WIDTH = 64;
    localparam int MSG_HEADER_MSB  = 63;
    localparam int MSG_HEADER_LSB  = 56;
    localparam int MSG_HEADER_W    = MSG_HEADER_MSB - MSG_HEADER_LSB + 1;

    localparam logic [MSG_HEADER_W-1:0] HEADER_RESULT = 8'hA5;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_SEND = 1'b1
    } arb_state_e;

    function automatic logic is_result_header(input logic [MSG_HEADER_W-1:0] hdr);
        return hdr == HEADER_RESULT;
    endfunction

endpackage

// File: rtl/ctrl_uplink_arbiter_if.sv
// ---------------------------------------------------------------------------
// ctrl_uplink_arbiter_if
// Bundles every non-clock/reset signal of the uplink arbiter.
//   data_from_children  : NUM_CHILDREN packed messages, child i in slice i
//   valid_from_children : per-child valid
//   ready_from_children : per-child ready (arbiter -> child)
//   data_to_root        : merged message stream
//   valid_to_root       : merged valid
//   ready_to_root       : root controller ready
//   clear_results       : one-cycle clear of the result counter
//   all_results         : one-cycle pulse when every child reported a result
//   uplink_busy         : a message is held anywhere in the arbiter
// Modport slave is the arbiter's view, master the environment's view.
// ---------------------------------------------------------------------------
interface ctrl_uplink_arbiter_if #(
    parameter int NUM_CHILDREN    = 4,
    parameter int CTRL_FIFO_WIDTH = ctrl_uplink_arbiter_pkg::CTRL_FIFO_WIDTH
);
    logic [NUM_CHILDREN*CTRL_FIFO_WIDTH-1:0] data_from_children;
    logic [NUM_CHILDREN-1:0]                 valid_from_children;
    logic [NUM_CHILDREN-1:0]                 ready_from_children;
    logic [CTRL_FIFO_WIDTH-1:0]              data_to_root;
    logic                                    valid_to_root;
    logic                                    ready_to_root;
    logic                                    clear_results;
    logic                                    all_results;
    logic                                    uplink_busy;

    modport slave (
        input  data_from_children, valid_from_children, ready_to_root, clear_results,
        output ready_from_children, data_to_root, valid_to_root, all_results, uplink_busy
    );

    modport master (
        output data_from_children, valid_from_children, ready_to_root, clear_results,
        input  ready_from_children, data_to_root, valid_to_root, all_results, uplink_busy
    );
endinterface

// File: rtl/ctrl_msg_fifo.sv
// ---------------------------------------------------------------------------
// ctrl_msg_fifo
// Per-child message buffer, DEPTH entries (power of two, >= 2).
//   clk, reset : clock, asynchronous active-low reset
//   push_i     : write data_i (ignored when full)
//   data_i     : message to write
//   pop_i      : drop the head entry (ignored when empty)
//   head_o     : oldest stored message
//   empty_o    : no entries stored
//   full_o     : all entries in use
// A push and a pop in the same cycle both take effect when not full.
// ---------------------------------------------------------------------------
module ctrl_msg_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: an entry is only observable once counted.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/ctrl_uplink_arbiter.sv
// ---------------------------------------------------------------------------
// ctrl_uplink_arbiter
// Merges NUM_CHILDREN child control-message streams into one stream towards
// the root controller. Each child has its own ctrl_msg_fifo; a round-robin
// arbiter moves buffered heads into a single output register. Result
// messages (header == HEADER_RESULT) are counted, and all_results pulses once
// NUM_CHILDREN of them have been forwarded.
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-low
//   bus   : ctrl_uplink_arbiter_if.slave (child/root handshakes, counter
//           clear, all_results, uplink_busy)
// ---------------------------------------------------------------------------
module ctrl_uplink_arbiter #(
    parameter int NUM_CHILDREN    = 4,
    parameter int CTRL_FIFO_WIDTH = ctrl_uplink_arbiter_pkg::CTRL_FIFO_WIDTH,
    parameter int BUF_DEPTH       = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    ctrl_uplink_arbiter_if.slave  bus
);
    import ctrl_uplink_arbiter_pkg::*;

    localparam int IDX_W = $clog2(NUM_CHILDREN);
    localparam int CNT_W = $clog2(NUM_CHILDREN + 1);

    logic [NUM_CHILDREN-1:0]    buf_empty, buf_full, buf_push, buf_pop;
    logic [NUM_CHILDREN-1:0]    child_ready;
    logic [CTRL_FIFO_WIDTH-1:0] buf_head [NUM_CHILDREN];

    logic                       rdy_en_q;
    arb_state_e                 state_q, state_d;
    logic [CTRL_FIFO_WIDTH-1:0] out_q, out_d;
    logic [IDX_W-1:0]           last_q, last_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       all_q, all_d;

    logic                       grant_vld;
    logic [IDX_W-1:0]           grant_idx;
    logic                       root_hs;
    logic                       counted;

    // Ready comes only from buffer occupancy and a post-reset enable flop, so
    // it is held low throughout reset and has no path from ready_to_root.
    assign child_ready             = ~buf_full & {NUM_CHILDREN{rdy_en_q}};
    assign bus.ready_from_children = child_ready;
    assign buf_push                = bus.valid_from_children & child_ready;

    for (genvar g = 0; g < NUM_CHILDREN; g++) begin : g_buf
        ctrl_msg_fifo #(
            .WIDTH (CTRL_FIFO_WIDTH),
            .DEPTH (BUF_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push_i  (buf_push[g]),
            .data_i  (bus.data_from_children[g*CTRL_FIFO_WIDTH +: CTRL_FIFO_WIDTH]),
            .pop_i   (buf_pop[g]),
            .head_o  (buf_head[g]),
            .empty_o (buf_empty[g]),
            .full_o  (buf_full[g])
        );
    end

    // Round-robin: first non-empty buffer searching upward from last_grant+1.
    always_comb begin : p_grant
        int cand;
        cand      = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_CHILDREN; k++) begin
            cand = int'(last_q) + 1 + k;
            if (cand >= NUM_CHILDREN) cand = cand - NUM_CHILDREN;
            if (!grant_vld && !buf_empty[cand]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
    end

    assign root_hs = (state_q == ARB_SEND) && bus.ready_to_root;

    // The output register may be refilled whenever it is empty or is being
    // drained this cycle, which gives one message per cycle back-to-back.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        last_d  = last_q;
        buf_pop = '0;
        if (state_q == ARB_IDLE || root_hs) begin
            if (grant_vld) begin
                out_d              = buf_head[grant_idx];
                buf_pop[grant_idx] = 1'b1;
                last_d             = grant_idx;
                state_d            = ARB_SEND;
            end else begin
                state_d = ARB_IDLE;
            end
        end
    end

    assign counted = root_hs && is_result_header(out_q[MSG_HEADER_MSB:MSG_HEADER_LSB]);

    // A clear coinciding with a counted handshake keeps that one result.
    always_comb begin
        cnt_d = cnt_q;
        all_d = 1'b0;
        if (bus.clear_results) begin
            cnt_d = counted ? CNT_W'(1) : '0;
        end else if (counted) begin
            if (cnt_q == CNT_W'(NUM_CHILDREN - 1)) begin
                cnt_d = '0;
                all_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_en_q <= 1'b0;
            state_q  <= ARB_IDLE;
            out_q    <= '0;
            last_q   <= IDX_W'(NUM_CHILDREN - 1);
            cnt_q    <= '0;
            all_q    <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            state_q  <= state_d;
            out_q    <= out_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            all_q    <= all_d;
        end
    end

    assign bus.valid_to_root = (state_q == ARB_SEND);
    assign bus.data_to_root  = out_q;
    assign bus.all_results   = all_q;
    assign bus.uplink_busy   = (state_q == ARB_SEND) || !(&buf_empty);
endmodule

// File: tb/tb_ctrl_uplink_arbiter.sv
module tb_ctrl_uplink_arbiter;
    import ctrl_uplink_arbiter_pkg::*;

    localparam int N = 4;
    localparam int W = 64;
    localparam int D = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ctrl_uplink_arbiter_if #(.NUM_CHILDREN(N), .CTRL_FIFO_WIDTH(W)) bus ();

    ctrl_uplink_arbiter #(
        .NUM_CHILDREN    (N),
        .CTRL_FIFO_WIDTH (W),
        .BUF_DEPTH       (D)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // What the coming clock edge does, captured just before it.
    logic         hs;
    logic [W-1:0] hs_word;
    logic [N-1:0] acc;

    // Reference model: one FIFO queue of expected words per child.
    logic [W-1:0] mq [N][$];

    function automatic logic [W-1:0] mk(input logic [7:0] hdr, input int ch, input int seq);
        return {hdr, 4'(ch), 52'(seq)};
    endfunction

    task automatic idle_inputs();
        bus.valid_from_children = '0;
        bus.data_from_children  = '0;
        bus.ready_to_root       = 1'b0;
        bus.clear_results       = 1'b0;
    endtask

    task automatic set_child(input int i, input logic [W-1:0] d);
        bus.data_from_children[i*W +: W] = d;
    endtask

    task automatic step();
        acc     = bus.valid_from_children & bus.ready_from_children;
        hs      = bus.valid_to_root && bus.ready_to_root;
        hs_word = bus.data_to_root;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) mq[i].delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Pops the expected word for the child encoded in the message.
    task automatic check_out(input string tag, input logic [W-1:0] w);
        int ch;
        ch = int'(w[55:52]);
        n_vec++;
        if (ch >= N || mq[ch].size() == 0) begin
            n_err++;
            $display("FAIL %s unexpected word got %h want none", tag, w);
        end else if (w !== mq[ch][0]) begin
            n_err++;
            $display("FAIL %s order got %h want %h", tag, w, mq[ch][0]);
            void'(mq[ch].pop_front());
        end else begin
            void'(mq[ch].pop_front());
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (bus.ready_from_children !== '0) begin n_err++; $display("FAIL reset_ready got %b want 0", bus.ready_from_children); end
        n_vec++; if (bus.valid_to_root !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.valid_to_root); end
        n_vec++; if (bus.data_to_root !== '0) begin n_err++; $display("FAIL reset_data got %h want 0", bus.data_to_root); end
        n_vec++; if (bus.all_results !== 1'b0) begin n_err++; $display("FAIL reset_all got %b want 0", bus.all_results); end
        n_vec++; if (bus.uplink_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.uplink_busy); end
        rst_n = 1'b1;
        #1;
        n_vec++; if (bus.ready_from_children !== '0) begin n_err++; $display("FAIL release_ready_early got %b want 0", bus.ready_from_children); end
        @(posedge clk);
        #1;
        n_vec++; if (bus.ready_from_children !== '1) begin n_err++; $display("FAIL release_ready got %b want 1111", bus.ready_from_children); end
    endtask

    task automatic test_latency();
        logic [W-1:0] w;
        w = 64'h00FF_0000_0000_00AA;
        bus.ready_to_root = 1'b1;
        set_child(2, w);
        bus.valid_from_children = 4'b0100;
        step();
        bus.valid_from_children = '0;
        n_vec++; if (acc !== 4'b0100) begin n_err++; $display("FAIL lat_accept got %b want 0100", acc); end
        n_vec++; if (bus.valid_to_root !== 1'b0) begin n_err++; $display("FAIL lat_early got %b want 0", bus.valid_to_root); end
        step();
        n_vec++; if (bus.valid_to_root !== 1'b1) begin n_err++; $display("FAIL lat_valid got %b want 1", bus.valid_to_root); end
        n_vec++; if (bus.data_to_root !== w) begin n_err++; $display("FAIL lat_data got %h want %h", bus.data_to_root, w); end
        step();
        n_vec++; if (hs !== 1'b1) begin n_err++; $display("FAIL lat_hs got %b want 1", hs); end
        n_vec++; if (bus.valid_to_root !== 1'b0) begin n_err++; $display("FAIL lat_one_cycle got %b want 0", bus.valid_to_root); end
    endtask

    task automatic test_back_to_back();
        int seq [N];
        int exp_ch;
        do_reset();
        for (int i = 0; i < N; i++) seq[i] = 0;
        exp_ch = 0;
        bus.ready_to_root = 1'b1;
        bus.valid_from_children = '1;
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < N; i++) set_child(i, mk(8'h00, i, seq[i]));
            step();
            for (int i = 0; i < N; i++) if (acc[i]) begin
                mq[i].push_back(mk(8'h00, i, seq[i]));
                seq[i]++;
            end
            if (hs) begin
                n_vec++;
                if (int'(hs_word[55:52]) !== exp_ch) begin
                    n_err++; $display("FAIL rr_child got %0d want %0d", hs_word[55:52], exp_ch);
                end
                exp_ch = (exp_ch + 1) % N;
                check_out("rr_data", hs_word);
            end else if (c >= 2) begin
                n_vec++; n_err++;
                $display("FAIL rr_throughput got no handshake want one at cycle %0d", c);
            end
        end
        bus.valid_from_children = '0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (hs) check_out("rr_drain", hs_word);
        end
        for (int i = 0; i < N; i++) begin
            n_vec++; if (mq[i].size() != 0) begin n_err++; $display("FAIL rr_loss child %0d got %0d left want 0", i, mq[i].size()); end
        end
    endtask

    task automatic test_backpressure();
        int seq, accepts;
        logic [W-1:0] prev;
        logic prev_v;
        do_reset();
        seq = 0; accepts = 0; prev_v = 1'b0; prev = '0;
        bus.ready_to_root = 1'b0;
        bus.valid_from_children = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            set_child(1, mk(8'h11, 1, seq));
            step();
            if (acc[1]) begin
                mq[1].push_back(mk(8'h11, 1, seq));
                seq++; accepts++;
            end
            if (prev_v && bus.valid_to_root) begin
                n_vec++; if (bus.data_to_root !== prev) begin n_err++; $display("FAIL bp_stable got %h want %h", bus.data_to_root, prev); end
            end
            prev_v = bus.valid_to_root; prev = bus.data_to_root;
        end
        n_vec++; if (accepts != D + 1) begin n_err++; $display("FAIL bp_accepts got %0d want %0d", accepts, D + 1); end
        n_vec++; if (bus.ready_from_children[1] !== 1'b0) begin n_err++; $display("FAIL bp_ready got %b want 0", bus.ready_from_children[1]); end
        n_vec++; if (bus.uplink_busy !== 1'b1) begin n_err++; $display("FAIL bp_busy got %b want 1", bus.uplink_busy); end
        bus.valid_from_children = '0;
        bus.ready_to_root = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (hs) check_out("bp_drain", hs_word);
        end
        n_vec++; if (mq[1].size() != 0) begin n_err++; $display("FAIL bp_loss got %0d left want 0", mq[1].size()); end
        n_vec++; if (bus.uplink_busy !== 1'b0) begin n_err++; $display("FAIL bp_idle_busy got %b want 0", bus.uplink_busy); end
    endtask

    // Sends nmsg result messages (children 0..nmsg-1), optionally asserts
    // clear_results on the clear_at-th output handshake, and expects a single
    // all_results pulse right after the pulse_at-th handshake (0: none).
    task automatic run_results(input int nmsg, input int clear_at, input int pulse_at, input string tag);
        int hs_num, pulses;
        hs_num = 0; pulses = 0;
        bus.ready_to_root = 1'b1;
        for (int i = 0; i < N; i++) set_child(i, mk(HEADER_RESULT, i, 7));
        bus.valid_from_children = '0;
        for (int i = 0; i < nmsg; i++) bus.valid_from_children[i] = 1'b1;
        step();
        bus.valid_from_children = '0;
        for (int c = 0; c < 20; c++) begin
            bus.clear_results = (bus.valid_to_root && bus.ready_to_root && hs_num + 1 == clear_at);
            step();
            bus.clear_results = 1'b0;
            if (hs) hs_num++;
            if (bus.all_results) begin
                pulses++;
                n_vec++;
                if (!(hs && hs_num == pulse_at)) begin
                    n_err++; $display("FAIL %s pulse_pos got after hs %0d want after hs %0d", tag, hs_num, pulse_at);
                end
            end
        end
        n_vec++; if (hs_num != nmsg) begin n_err++; $display("FAIL %s hs_count got %0d want %0d", tag, hs_num, nmsg); end
        n_vec++; if (pulses != ((pulse_at > 0) ? 1 : 0)) begin n_err++; $display("FAIL %s pulses got %0d want %0d", tag, pulses, (pulse_at > 0) ? 1 : 0); end
    endtask

    task automatic test_results();
        do_reset();
        run_results(4, 0, 4, "res4");
        run_results(4, 0, 4, "res4_again");
        run_results(4, 3, 0, "clr_on_3rd");
        run_results(2, 0, 2, "after_clr");
        run_results(2, 0, 0, "partial");
        bus.clear_results = 1'b1;
        step();
        bus.clear_results = 1'b0;
        run_results(4, 0, 4, "after_clear_alone");
    endtask

    task automatic test_reset_midflight();
        int seen;
        do_reset();
        bus.ready_to_root = 1'b0;
        for (int i = 0; i < N; i++) set_child(i, mk(8'h33, i, 99));
        bus.valid_from_children = '1;
        step();
        bus.valid_from_children = '0;
        step();
        step();
        n_vec++; if (bus.valid_to_root !== 1'b1) begin n_err++; $display("FAIL mid_send got %b want 1", bus.valid_to_root); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (bus.valid_to_root !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got %b want 0", bus.valid_to_root); end
        n_vec++; if (bus.uplink_busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy got %b want 0", bus.uplink_busy); end
        bus.ready_to_root = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (bus.valid_to_root !== 1'b0) begin n_err++; $display("FAIL mid_rst_hold got %b want 0", bus.valid_to_root); end
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.valid_to_root) seen++;
        end
        n_vec++; if (seen != 0) begin n_err++; $display("FAIL mid_old_msg got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_random();
        int cnt, ch;
        logic clr, counted, pulse;
        logic [7:0] hdr;
        logic [W-1:0] w [N];
        do_reset();
        cnt = 0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                hdr  = ($urandom_range(0, 2) == 0) ? HEADER_RESULT : 8'($urandom_range(0, 255));
                w[i] = mk(hdr, i, int'($urandom));
                set_child(i, w[i]);
                bus.valid_from_children[i] = ($urandom_range(0, 1) == 1);
            end
            bus.ready_to_root = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 19) == 0);
            bus.clear_results = clr;
            step();
            for (int i = 0; i < N; i++) if (acc[i]) mq[i].push_back(w[i]);
            if (hs) check_out("rnd_data", hs_word);
            counted = hs && (hs_word[63:56] == HEADER_RESULT);
            pulse = 1'b0;
            if (clr) cnt = counted ? 1 : 0;
            else if (counted) begin
                cnt++;
                if (cnt == N) begin pulse = 1'b1; cnt = 0; end
            end
            n_vec++; if (bus.all_results !== pulse) begin n_err++; $display("FAIL rnd_all cycle %0d got %b want %b", c, bus.all_results, pulse); end
        end
        bus.valid_from_children = '0;
        bus.clear_results = 1'b0;
        bus.ready_to_root = 1'b1;
        for (int c = 0; c < 30; c++) begin
            step();
            if (hs) check_out("rnd_drain", hs_word);
        end
        for (int i = 0; i < N; i++) begin
            n_vec++; if (mq[i].size() != 0) begin n_err++; $display("FAIL rnd_loss child %0d got %0d left want 0", i, mq[i].size()); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_results();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
